// File: rtl/feature_bram_loader.sv
// Packs KERNEL_SIZE serial signed pixels per word and writes WORDS words to the feature BRAM.
// One write-strobe cycle per word (ready low there); load_down pulses one cycle after the final write.
module feature_bram_loader #(
   parameter int IN_WIDTH    = 8,
   parameter int IMAGE       = 32,
   parameter int KERNEL_SIZE = 5,
   parameter int WORDS       = IMAGE,
   localparam int AW = (IMAGE > 1) ? $clog2(IMAGE) : 1,
   localparam int LW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1,
   localparam int DW = KERNEL_SIZE * IN_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                pixel_valid,
   input  logic [IN_WIDTH-1:0] nextPixel,
   output logic                pixel_ready,
   output logic                bram_select_en,
   output logic [AW-1:0]       bram_addr_f,
   output logic [DW-1:0]       bram_data_f,
   output logic                busy,
   output logic                load_down
);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t        state;
   state_t        state_next;
   logic [LW-1:0] lane_cnt;
   logic [AW-1:0] word_cnt;
   logic [DW-1:0] pack;
   logic [DW-1:0] word_next;
   logic          accept;
   logic          last_lane;
   logic          last_word;

   assign accept    = pixel_valid && pixel_ready;
   assign last_lane = (lane_cnt == LW'(KERNEL_SIZE - 1));
   assign last_word = (word_cnt == AW'(WORDS - 1));

   // The last lane goes straight from the input into the output register.
   always_comb begin
      word_next = pack;
      word_next[(KERNEL_SIZE-1)*IN_WIDTH +: IN_WIDTH] = nextPixel;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      pixel_ready    = 1'b0;
      bram_select_en = 1'b0;
      busy           = 1'b1;
      load_down      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = FILL;
         end
         FILL: begin
            pixel_ready = 1'b1;
            if (pixel_valid && last_lane) state_next = WRITE;
         end
         WRITE: begin
            bram_select_en = 1'b1;
            state_next     = last_word ? DONE : FILL;
         end
         DONE: begin
            load_down  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         lane_cnt    <= '0;
         word_cnt    <= '0;
         pack        <= '0;
         bram_addr_f <= '0;
         bram_data_f <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lane_cnt <= '0;
                  word_cnt <= '0;
               end
            end
            FILL: begin
               if (accept) begin
                  if (last_lane) begin
                     lane_cnt    <= '0;
                     bram_addr_f <= word_cnt;
                     bram_data_f <= word_next;
                  end else begin
                     lane_cnt <= lane_cnt + 1'b1;
                     pack[lane_cnt*IN_WIDTH +: IN_WIDTH] <= nextPixel;
                  end
               end
            end
            WRITE: word_cnt <= word_cnt + 1'b1;
            DONE: begin
               word_cnt    <= '0;
               bram_addr_f <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_feature_bram_loader.sv
// Bench for feature_bram_loader: directed and randomized loads against a pixel-array reference.
module tb_feature_bram_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, pixel_valid;
   logic [7:0]  nextPixel;
   logic        pixel_ready, bram_select_en, busy, load_down;
   logic [4:0]  bram_addr_f;
   logic [39:0] bram_data_f;

   logic        start1, pixel_valid1;
   logic [7:0]  nextPixel1;
   logic        pixel_ready1, bram_select_en1, busy1, load_down1;
   logic [4:0]  bram_addr_f1;
   logic [39:0] bram_data_f1;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  pix [0:159];
   logic [39:0] got_word [0:31];

   always #5 clk = ~clk;

   feature_bram_loader dut (
      .clk(clk), .rst(rst), .start(start), .pixel_valid(pixel_valid), .nextPixel(nextPixel),
      .pixel_ready(pixel_ready), .bram_select_en(bram_select_en), .bram_addr_f(bram_addr_f),
      .bram_data_f(bram_data_f), .busy(busy), .load_down(load_down)
   );

   feature_bram_loader #(.WORDS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .pixel_valid(pixel_valid1), .nextPixel(nextPixel1),
      .pixel_ready(pixel_ready1), .bram_select_en(bram_select_en1), .bram_addr_f(bram_addr_f1),
      .bram_data_f(bram_data_f1), .busy(busy1), .load_down(load_down1)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Word n holds pixels 5n..5n+4, first pixel in the least significant byte.
   function automatic logic [39:0] model_word(input int n);
      logic [39:0] w = '0;
      for (int k = 0; k < 5; k++) w = w | (40'(pix[5*n+k]) << (8*k));
      return w;
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, pixel_ready, 0);
      chk({tag, "_sel"}, bram_select_en, 0);
      chk({tag, "_addr"}, bram_addr_f, 0);
      chk({tag, "_data"}, bram_data_f, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, load_down, 0);
   endtask

   // vmode: 0 = valid held high, 1 = valid toggling, 2 = random valid.
   task automatic run_load(input int vmode, input int abort_after, input bit glitch);
      int  idx = 0, nstrobe = 0, done_rel = -1, last_rel = -1, seen;
      bit  fin = 0, aborted = 0;
      logic v;
      start = 1'b1;
      pixel_valid = 1'b0;
      @(negedge clk);
      chk("idle_busy_before_start", busy, 0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int rel = 1; rel < 1000 && !fin; rel++) begin
         case (vmode)
            0:       v = 1'b1;
            1:       v = rel[0];
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         pixel_valid = v;
         nextPixel = (idx < 160) ? pix[idx] : 8'h00;
         if (glitch) start = (rel == 2 || rel == 6);
         @(negedge clk);
         chk("done_sel_exclusive", {7'd0, load_down & bram_select_en}, 0);
         if (bram_select_en) begin
            chk("ready_low_on_write", pixel_ready, 0);
            chk("wr_addr", bram_addr_f, nstrobe);
            chk("wr_pixels_accepted", idx, 5*(nstrobe+1));
            chk("wr_data", bram_data_f, model_word(nstrobe));
            if (vmode == 0) chk("wr_cycle", rel, 6*(nstrobe+1));
            if (nstrobe < 32) got_word[nstrobe] = bram_data_f;
            nstrobe++;
            last_rel = rel;
         end
         if (load_down) begin
            done_rel = rel;
            fin = 1;
         end
         if (pixel_valid && pixel_ready) idx++;
         if (abort_after > 0 && idx == abort_after) begin
            chk("strobes_before_abort", nstrobe, 2);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("abort");
            @(posedge clk); #1;
            rst = 1'b1;
            pixel_valid = 1'b1;
            seen = 0;
            repeat (15) begin
               @(negedge clk);
               if (bram_select_en || pixel_ready) seen++;
               @(posedge clk); #1;
            end
            chk("quiet_after_abort", seen, 0);
            pixel_valid = 1'b0;
            fin = 1;
            aborted = 1;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      pixel_valid = 1'b0;
      if (!aborted) begin
         chk("strobe_count", nstrobe, 32);
         chk("done_after_last_write", done_rel, last_rel + 1);
         if (vmode == 0) chk("done_cycle", done_rel, 193);
      end
   endtask

   initial begin
      int idx1, n1, done1;
      rst = 1'b0;
      start = 1'b0; pixel_valid = 1'b0; nextPixel = '0;
      start1 = 1'b0; pixel_valid1 = 1'b0; nextPixel1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      chk("reset1_busy", busy1, 0);
      chk("reset1_sel", bram_select_en1, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Basic load, sequential pixels, continuous valid
      for (int i = 0; i < 160; i++) pix[i] = 8'(i);
      run_load(0, 0, 0);
      chk("basic_word0", got_word[0], 40'h0403020100);
      chk("basic_word31", got_word[31], 40'h9F9E9D9C9B);
      @(negedge clk);
      chk("idle_after_done", busy, 0);
      @(posedge clk); #1;

      // Bubbles: same stream with valid toggling
      run_load(1, 0, 0);
      chk("bubble_word31", got_word[31], 40'h9F9E9D9C9B);
      @(posedge clk); #1;

      // Signed extremes in word 0, random remainder and random valid
      for (int i = 0; i < 160; i++) pix[i] = 8'($urandom);
      pix[0] = 8'hFF; pix[1] = 8'h80; pix[2] = 8'h7F; pix[3] = 8'h00; pix[4] = 8'h01;
      run_load(2, 0, 0);
      chk("signed_word0", got_word[0], 40'h01007F80FF);
      @(posedge clk); #1;

      // Reset mid-load, fresh load, then back-to-back load with ignored start pulses
      for (int i = 0; i < 160; i++) pix[i] = 8'(i);
      run_load(0, 12, 0);
      run_load(0, 0, 0);
      run_load(0, 0, 1);
      @(posedge clk); #1;

      // Fully random pixels and valid pattern
      for (int i = 0; i < 160; i++) pix[i] = 8'($urandom);
      run_load(2, 0, 0);
      @(posedge clk); #1;

      // Single-word configuration
      idx1 = 0; n1 = 0; done1 = -1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      for (int rel = 1; rel < 20; rel++) begin
         pixel_valid1 = 1'b1;
         nextPixel1 = (idx1 < 160) ? pix[idx1] : 8'h00;
         @(negedge clk);
         if (bram_select_en1) begin
            chk("w1_addr", bram_addr_f1, 0);
            chk("w1_data", bram_data_f1, model_word(0));
            chk("w1_cycle", rel, 6);
            n1++;
         end
         if (load_down1) done1 = rel;
         if (pixel_valid1 && pixel_ready1) idx1++;
         @(posedge clk); #1;
      end
      pixel_valid1 = 1'b0;
      chk("w1_strobes", n1, 1);
      chk("w1_done_cycle", done1, 7);
      chk("w1_pixels", idx1, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/feature_bram_loader.md
# feature_bram_loader

Write-side front end for the feature-map dual-port BRAM consumed by the convolution blocks. Accepts a serial stream of signed pixels, packs `KERNEL_SIZE` consecutive pixels into one BRAM word, and drives the `bram_select_en` / `bram_addr_f` / `bram_data_f` write port at sequential addresses. Pulses `load_down` once the configured number of words has been written, releasing the convolution engine to start.

## Interface
- `IN_WIDTH`, 8, pixel width in bits (signed)
- `IMAGE`, 32, BRAM depth in words; address width is `clogb2(IMAGE)`
- `KERNEL_SIZE`, 5, pixels packed per BRAM word
- `WORDS`, `IMAGE`, words written per load; legal range 1..`IMAGE`

- `clk`  in  1  single clock for all logic; the BRAM's `clk_mem` is tied to this clock
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE
- `pixel_valid`  in  1  `nextPixel` holds a valid pixel
- `nextPixel`  in  `IN_WIDTH`  signed pixel data
- `pixel_ready`  out  1  block accepts a pixel this cycle
- `bram_select_en`  out  1  BRAM write enable (drives `we1`/`we2`)
- `bram_addr_f`  out  `clogb2(IMAGE)`  BRAM write address
- `bram_data_f`  out  `KERNEL_SIZE*IN_WIDTH`  packed BRAM write data
- `busy`  out  1  load in progress (any state other than IDLE)
- `load_down`  out  1  one-cycle pulse: load complete

## Operation
- A pixel is accepted on any rising edge where `pixel_valid && pixel_ready`.
- States: IDLE, FILL, WRITE, DONE.
- IDLE: `pixel_ready=0`. `start=1` moves to FILL and clears the lane counter and word counter. The address is already 0.
- FILL: `pixel_ready=1`. Each accepted pixel goes into lane `lane_cnt`, occupying bits `[(lane_cnt+1)*IN_WIDTH-1 : lane_cnt*IN_WIDTH]`. The first pixel of a word lands in the LSB lane. `lane_cnt` then increments.
- FILL -> WRITE: on acceptance of the pixel with `lane_cnt == KERNEL_SIZE-1`. `lane_cnt` returns to 0.
- FILL with `pixel_valid=0`: hold state; no counter changes.
- WRITE: exactly one cycle.
  - `pixel_ready=0`.
  - `bram_select_en=1`; `bram_addr_f` = word counter; `bram_data_f` = packed word.
  - Word counter increments.
  - If this was word `WORDS-1`, go to DONE; otherwise go back to FILL.
- DONE: exactly one cycle.
  - `load_down=1`.
  - Address/word counter resets to 0.
  - Next state is IDLE.
- `start` asserted outside IDLE is ignored; no queuing.
- No partial-word flush. A load only ends after `WORDS*KERNEL_SIZE` pixels have been accepted.
- Pixels are stored bit-exact; no sign extension or arithmetic.
- `bram_data_f` and `bram_addr_f` are registered.
  - They hold their last values outside WRITE.
  - They are only meaningful while `bram_select_en=1`.
- `busy=1` in FILL, WRITE and DONE.

## Timing
- Reset values (`rst=0` at a rising edge): state IDLE; `pixel_ready=0`, `bram_select_en=0`, `bram_addr_f=0`, `bram_data_f=0`, `busy=0`, `load_down=0`. All counters are 0.
- Reset asserted mid-load aborts immediately. The next cycle shows the reset values.
  - No further write strobe occurs.
  - The partial word is discarded.
  - BRAM contents already written are untouched.
- Write latency: `bram_select_en` is high in the cycle after the `KERNEL_SIZE`-th pixel of a word is accepted.
- Throughput with `pixel_valid` held high: `KERNEL_SIZE` pixels per `KERNEL_SIZE+1` cycles.
- Full-load duration with continuous valid: `start` at cycle 0; FILL entered at cycle 1; first write strobe at cycle `1+KERNEL_SIZE`.
  - Last write strobe at cycle `WORDS*(KERNEL_SIZE+1)`.
  - `load_down` at cycle `WORDS*(KERNEL_SIZE+1)+1`.
  - IDLE on the following cycle.
  - Defaults: write strobes at cycles 6, 12, …, 192; `load_down` at 193.
- `pixel_ready` is a pure function of state (high only in FILL). It has no combinational path from `pixel_valid`.
- `load_down` and `bram_select_en` are never high in the same cycle.

## Test plan
- Basic load, defaults: `start`, then pixels 0..159 with `pixel_valid` held high.
  - Required: 32 strobes at addresses 0..31.
  - Word n has lane k = 5n+k; e.g. addr 0 data = 0x0403020100, addr 31 data = 0x9F9E9D9C9B.
  - `load_down` pulse at cycle 193, then `busy=0`.
- Bubbles: the same stream with `pixel_valid` toggling 1/0 every cycle.
  - Required: identical BRAM contents.
  - No strobe occurs until 5 pixels have been accepted.
  - `pixel_ready` is low on every WRITE cycle.
- Signed data: pixels −1, −128, 127, 0, 1 into word 0.
  - Required: `bram_data_f` = 0x01007F80FF on its strobe.
- Reset mid-load: assert `rst=0` after 12 pixels (2 words written plus 2 lanes filled).
  - Required: all outputs at reset values next cycle; no third strobe.
  - A fresh `start` after reset writes from address 0.
- Ignored start and back-to-back loads: pulse `start` during FILL and again during WRITE.
  - Required: no effect; the load completes normally.
  - A `start` on the cycle after `load_down` (IDLE) begins a new load at address 0.
- `WORDS=1`: `start` plus 5 pixels.
  - Required: a single strobe at address 0, with `load_down` on the next cycle.
